// File: rtl/main_mem_ctrl_pkg.sv
// Shared types and helpers for the main-memory line-burst controller.
// Arbitration mode is selected by MAIN_MEM_CTRL_RR_EN (see rr_arb2).
package main_mem_ctrl_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        DRAIN = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } state_t;

    // Number of word-offset bits inside one cache line.
    function automatic int offset_bits(input int line_words);
        return $clog2(line_words);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way request arbiter producing a one-hot (or zero) grant.
// MAIN_MEM_CTRL_RR_EN defined: round-robin, pointer flips to the other
// requester after every accepted grant. Undefined: requester 0 always wins.
module rr_arb2
    import main_mem_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] gnt
);

`ifdef MAIN_MEM_CTRL_RR_EN
    logic ptr;

    // Pointer moves to the requester that was not just served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (advance) begin
            ptr <= gnt[0];
        end
    end

    // On a tie the pointer decides; a lone requester always wins.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end
`else
    logic unused_arb;
    assign unused_arb = &{1'b0, clk, rst, advance};

    // Requester 0 masks requester 1 whenever both are asking.
    always_comb begin
        gnt = req;
        if (req[0]) begin
            gnt[1] = 1'b0;
        end
    end
`endif

endmodule

// File: rtl/main_mem_ctrl.sv
// Line-burst controller sharing one 1W/1R word RAM between two cache
// requesters. Each grant moves LINE_WORDS words; a read returns the whole
// line on rsp_rdata, a write returns an ack. Arbitration mode is selected
// with MAIN_MEM_CTRL_RR_EN (round-robin when defined, fixed otherwise).
module main_mem_ctrl
    import main_mem_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [1:0]                         req_valid,
    output logic [1:0]                         req_ready,
    input  logic [1:0]                         req_write,
    input  logic [2*ADDR_WIDTH-1:0]            req_addr,
    input  logic [2*LINE_WORDS*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                         rsp_valid,
    input  logic [1:0]                         rsp_ready,
    output logic [LINE_WORDS*DATA_WIDTH-1:0]   rsp_rdata,
    output logic                               ram_w_en,
    output logic [ADDR_WIDTH-1:0]              ram_w_addr,
    output logic [DATA_WIDTH-1:0]              ram_w_data,
    output logic                               ram_r_en,
    output logic [ADDR_WIDTH-1:0]              ram_r_addr,
    input  logic [DATA_WIDTH-1:0]              ram_r_data
);

    localparam int OB = offset_bits(LINE_WORDS);
    localparam int LB = LINE_WORDS * DATA_WIDTH;
    localparam logic [OB-1:0] LAST = OB'(LINE_WORDS - 1);

    state_t                  state, state_nxt;
    logic [OB-1:0]           cnt;
    logic                    sel;
    logic [ADDR_WIDTH-1:0]   base;
    logic [DATA_WIDTH-1:0]   wline [LINE_WORDS];
    logic [DATA_WIDTH-1:0]   rline [LINE_WORDS];
    logic [ADDR_WIDTH-1:0]   w_addr_q, r_addr_q;
    logic [DATA_WIDTH-1:0]   w_data_q;
    logic [1:0]              gnt;
    logic                    gidx;
    logic                    accept;
    logic [ADDR_WIDTH-1:0]   cur_addr;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [LB-1:0]           sel_line;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (accept),
        .gnt     (gnt)
    );

    assign gidx     = gnt[1];
    assign accept   = |(req_ready & req_valid);
    assign sel_addr = gidx ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
    assign sel_line = gidx ? req_wdata[2*LB-1:LB] : req_wdata[LB-1:0];
    // Offset field only: the burst wraps inside the line, never carries out.
    assign cur_addr = {base[ADDR_WIDTH-1:OB], cnt};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing of one line transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_write[gidx] ? WRITE : READ;
            READ:    if (cnt == LAST) state_nxt = DRAIN;
            DRAIN:   state_nxt = RESP;
            WRITE:   if (cnt == LAST) state_nxt = RESP;
            RESP:    if (rsp_ready[sel]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state; idle RAM address/data show the last value driven.
    always_comb begin
        req_ready  = '0;
        rsp_valid  = '0;
        ram_w_en   = 1'b0;
        ram_r_en   = 1'b0;
        ram_w_addr = w_addr_q;
        ram_w_data = w_data_q;
        ram_r_addr = r_addr_q;
        case (state)
            IDLE:  if (!rst) req_ready = gnt;
            WRITE: begin
                ram_w_en   = 1'b1;
                ram_w_addr = cur_addr;
                ram_w_data = wline[cnt];
            end
            READ: begin
                ram_r_en   = 1'b1;
                ram_r_addr = cur_addr;
            end
            RESP:  rsp_valid[sel] = 1'b1;
            default: ;
        endcase
    end

    // Burst control, address hold registers and read-line capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            sel      <= 1'b0;
            base     <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            r_addr_q <= '0;
            for (int i = 0; i < LINE_WORDS; i++) rline[i] <= '0;
        end else begin
            if (accept) begin
                sel  <= gidx;
                base <= {sel_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
                cnt  <= '0;
            end
            if (state == READ || state == WRITE) begin
                cnt <= cnt + 1'b1;
            end
            if (state == WRITE) begin
                w_addr_q <= cur_addr;
                w_data_q <= wline[cnt];
            end
            if (state == READ) begin
                r_addr_q <= cur_addr;
                // RAM returns the word requested one cycle earlier.
                if (cnt != '0) rline[cnt - 1'b1] <= ram_r_data;
            end
            if (state == DRAIN) begin
                rline[LINE_WORDS-1] <= ram_r_data;
            end
        end
    end

    // Write line captured from the winner at accept; pure data, no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                wline[i] <= sel_line[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < LINE_WORDS; g++) begin : g_rdata
            assign rsp_rdata[g*DATA_WIDTH +: DATA_WIDTH] = rline[g];
        end
    endgenerate

endmodule

// File: tb/tb_main_mem_ctrl.sv
// Testbench for main_mem_ctrl: RAM model, spec-level reference model with a
// per-cycle compare process, and directed scenarios with literal expectations.
module tb_main_mem_ctrl;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int L  = 4;
`ifdef MAIN_MEM_CTRL_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        req_valid = '0;
    logic [1:0]        req_ready;
    logic [1:0]        req_write = '0;
    logic [2*AW-1:0]   req_addr = '0;
    logic [2*L*DW-1:0] req_wdata = '0;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready = 2'b11;
    logic [L*DW-1:0]   rsp_rdata;
    logic              ram_w_en;
    logic [AW-1:0]     ram_w_addr;
    logic [DW-1:0]     ram_w_data;
    logic              ram_r_en;
    logic [AW-1:0]     ram_r_addr;
    bit   [DW-1:0]     ram_r_data;

    bit [DW-1:0] ram_mem [0:65535];
    bit [DW-1:0] ref_mem [0:65535];

    int n_checks = 0;
    int n_fail   = 0;

    main_mem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LINE_WORDS(L)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data)
    );

    always #5 clk = ~clk;

    // Word RAM: one write port, one registered read port.
    always @(posedge clk) begin
        if (ram_w_en) ram_mem[ram_w_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= ram_mem[ram_r_addr];
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_winner(input logic [1:0] v, input bit ptr);
        if (v == 2'b11) return (RR_MODE && ptr) ? 2'b10 : 2'b01;
        return v;
    endfunction

    // Reference model state: one transaction in flight, counted in cycles since accept.
    bit            m_active = 1'b0;
    int            m_t;
    int            m_k;
    bit            m_wr;
    bit            m_ptr = 1'b0;
    logic [AW-1:0] m_base;
    logic [DW-1:0] m_line [L];
    logic [1:0]    m_w;
    logic [1:0]    m_ev;
    logic [L*DW-1:0] m_exp;
    int            grants [$];

    // Compare DUT outputs with the model every cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_ptr    = 1'b0;
        end else if (!m_active) begin
            m_w = exp_winner(req_valid, m_ptr);
            check("idle_req_ready", 128'(req_ready), 128'(m_w));
            check("idle_rsp_valid", 128'(rsp_valid), 128'(0));
            check("idle_ram_en", 128'({ram_w_en, ram_r_en}), 128'(0));
            if (m_w != 2'b00) begin
                m_active = 1'b1;
                m_t      = 0;
                m_k      = m_w[1] ? 1 : 0;
                m_wr     = req_write[m_k];
                m_base   = req_addr[m_k*AW +: AW] & ~AW'(L-1);
                for (int i = 0; i < L; i++) m_line[i] = req_wdata[(m_k*L+i)*DW +: DW];
                if (m_wr) for (int i = 0; i < L; i++) ref_mem[AW'(m_base+i)] = m_line[i];
                m_ptr = (m_w == 2'b01);
                grants.push_back(m_k);
            end
        end else begin
            m_t++;
            m_ev = (m_k == 1) ? 2'b10 : 2'b01;
            check("busy_req_ready", 128'(req_ready), 128'(0));
            if (m_t <= L) begin
                check("burst_rsp_valid", 128'(rsp_valid), 128'(0));
                if (m_wr) begin
                    check("wr_en", 128'({ram_w_en, ram_r_en}), 128'(2'b10));
                    check("wr_addr", 128'(ram_w_addr), 128'(AW'(m_base + m_t - 1)));
                    check("wr_data", 128'(ram_w_data), 128'(m_line[m_t-1]));
                end else begin
                    check("rd_en", 128'({ram_w_en, ram_r_en}), 128'(2'b01));
                    check("rd_addr", 128'(ram_r_addr), 128'(AW'(m_base + m_t - 1)));
                end
            end else if (!m_wr && m_t == L + 1) begin
                check("drain_en", 128'({ram_w_en, ram_r_en}), 128'(0));
                check("drain_rsp_valid", 128'(rsp_valid), 128'(0));
            end else begin
                check("resp_valid", 128'(rsp_valid), 128'(m_ev));
                check("resp_en", 128'({ram_w_en, ram_r_en}), 128'(0));
                if (!m_wr) begin
                    for (int i = 0; i < L; i++) m_exp[i*DW +: DW] = ref_mem[AW'(m_base+i)];
                    check("resp_rdata", 128'(rsp_rdata), 128'(m_exp));
                end
                if (rsp_ready[m_k]) m_active = 1'b0;
            end
        end
    end

    // Present a request, wait for accept, then time the response in cycles after accept.
    task automatic line_req(input int k, input bit wr, input logic [AW-1:0] addr,
                            input logic [L*DW-1:0] line, output int lat, output logic [L*DW-1:0] rd);
        int n;
        @(posedge clk); #1;
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k*AW +: AW] = addr;
        req_wdata[k*L*DW +: L*DW] = line;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[k] && n < 50);
        check("accept_seen", 128'(req_ready[k]), 128'(1));
        @(posedge clk); #1;
        req_valid[k] = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!rsp_valid[k] && lat < 50);
        rd = rsp_rdata;
        while (!rsp_ready[k]) @(negedge clk);
        @(posedge clk);
    endtask

    localparam logic [DW-1:0] WA = 32'hA0A0_0001, WB = 32'hB0B0_0002,
                              WC = 32'hC0C0_0003, WD = 32'hD0D0_0004;
    localparam logic [DW-1:0] WE = 32'h1234_5678, WF = 32'h9ABC_DEF0,
                              WG = 32'h0F0F_F0F0, WH = 32'hCAFE_BABE;

    int              lat;
    logic [L*DW-1:0] rd;
    int              n;
    logic [L*DW-1:0] held;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check("rst_req_ready", 128'(req_ready), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_ram_en", 128'({ram_w_en, ram_r_en}), 128'(0));
        check("rst_rdata", 128'(rsp_rdata), 128'(0));
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Test 1: reset in the middle of a read burst
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[AW-1:0] = 16'h0010;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        check("t1_accept", 128'(req_ready[0]), 128'(1));
        @(posedge clk); #1 req_valid[0] = 1'b0;
        @(posedge clk); #1;
        check("t1_mid_read", 128'(ram_r_en), 128'(1));
        rst = 1'b1;
        #1;
        check("t1_req_ready", 128'(req_ready), 128'(0));
        check("t1_rsp_valid", 128'(rsp_valid), 128'(0));
        check("t1_ram_en", 128'({ram_w_en, ram_r_en}), 128'(0));
        check("t1_ram_addr", 128'({ram_w_addr, ram_r_addr}), 128'(0));
        check("t1_ram_wdata", 128'(ram_w_data), 128'(0));
        check("t1_rdata", 128'(rsp_rdata), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            check("t1_no_rsp", 128'(rsp_valid), 128'(0));
        end

        // Test 2: requester 0 line write, unaligned address
        line_req(0, 1'b1, 16'h0013, {WD, WC, WB, WA}, lat, rd);
        check("t2_latency", 128'(lat), 128'(5));
        check("t2_mem10", 128'(ram_mem[16'h0010]), 128'(WA));
        check("t2_mem11", 128'(ram_mem[16'h0011]), 128'(WB));
        check("t2_mem12", 128'(ram_mem[16'h0012]), 128'(WC));
        check("t2_mem13", 128'(ram_mem[16'h0013]), 128'(WD));

        // Test 3: requester 1 line read
        line_req(1, 1'b0, 16'h0010, '0, lat, rd);
        check("t3_latency", 128'(lat), 128'(6));
        check("t3_rdata", 128'(rd), 128'({WD, WC, WB, WA}));

        // Test 4: both requesters valid continuously
        grants.delete();
        @(posedge clk); #1;
        req_write = 2'b00;
        req_addr  = {16'h0010, 16'h0010};
        req_valid = 2'b11;
        n = 0;
        while (grants.size() < 4 && n < 400) begin @(negedge clk); n++; end
        @(posedge clk); #1 req_valid = 2'b00;
        repeat (15) @(posedge clk);
        check("t4_count", 128'(grants.size()), 128'(4));
        for (int i = 0; i < 4; i++) begin
            if (grants.size() > i)
                check("t4_grant", 128'(grants[i]), 128'(RR_MODE ? (i % 2) : 0));
        end

        // Test 5: response back-pressure holds state and blocks the other requester
        rsp_ready[0] = 1'b0;
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_write[0] = 1'b0; req_addr[AW-1:0] = 16'h0011;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[0] && n < 50);
        check("t5_accept0", 128'(req_ready[0]), 128'(1));
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[2*AW-1:AW] = 16'h0012;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid[0] && n < 50);
        check("t5_latency", 128'(n), 128'(6));
        held = rsp_rdata;
        check("t5_rdata", 128'(held), 128'({WD, WC, WB, WA}));
        repeat (10) begin
            @(negedge clk);
            check("t5_hold_valid", 128'(rsp_valid), 128'(2'b01));
            check("t5_hold_rdata", 128'(rsp_rdata), 128'(held));
            check("t5_no_accept", 128'(req_ready), 128'(0));
        end
        @(posedge clk); #1 rsp_ready[0] = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!req_ready[1] && n < 50);
        check("t5_accept1", 128'(req_ready[1]), 128'(1));
        check("t5_accept1_delay", 128'(n), 128'(2));
        @(posedge clk); #1 req_valid[1] = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid[1] && n < 50);
        check("t5_rdata1", 128'(rsp_rdata), 128'({WD, WC, WB, WA}));
        @(posedge clk);

        // Test 6: top-of-memory line, no wrap past the line
        line_req(1, 1'b1, 16'hFFFC, {WH, WG, WF, WE}, lat, rd);
        check("t6_wr_latency", 128'(lat), 128'(5));
        check("t6_memFFFF", 128'(ram_mem[16'hFFFF]), 128'(WH));
        check("t6_mem0000", 128'(ram_mem[16'h0000]), 128'(0));
        line_req(0, 1'b0, 16'hFFFF, '0, lat, rd);
        check("t6_rd_latency", 128'(lat), 128'(6));
        check("t6_rdata", 128'(rd), 128'({WH, WG, WF, WE}));

        repeat (4) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
